// File: rtl/std_types.sv
// std_types: shared scalar types, default widths and the arbiter state enum.
package std_types;
    typedef logic bool;
    typedef logic [7:0] u8;
    localparam int U8 = 8;
    typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
endpackage

// File: rtl/binmux.sv
// binmux: two-input data selector, sel=1 picks in1.
module binmux
    import std_types::*;
#(
    parameter int DATA_WIDTH = U8
) (
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/binmux_arb.sv
// binmux_arb: two-requester round-robin arbiter feeding one registered output slot.
// Define BINMUX_ARB_STATS_EN to add saturating per-requester grant counters.
module binmux_arb
    import std_types::*;
#(
    parameter int DATA_WIDTH = U8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in0_valid,
    input  logic [DATA_WIDTH-1:0] in0_data,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  in1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
`ifdef BINMUX_ARB_STATS_EN
    output u8                     in0_grants,
    output u8                     in1_grants,
`endif
    output logic                  out_src
);
    arb_state_t            state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, mux_data;
    logic                  out_src_q, out_src_d;
    logic                  take, sel;
    bool                   xfer;
`ifdef BINMUX_ARB_STATS_EN
    u8                     grants0_q, grants0_d, grants1_q, grants1_d;
`endif

    assign take = (state_q == ARB_EMPTY) || out_ready;
    // Under contention the requester not granted last time wins.
    assign sel  = (in0_valid && in1_valid) ? !last_gnt_q : in1_valid;
    assign xfer = take && (sel ? in1_valid : in0_valid);

    binmux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
        .sel (sel),
        .in0 (in0_data),
        .in1 (in1_data),
        .out (mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_EMPTY;
            last_gnt_q <= 1'b1;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
`ifdef BINMUX_ARB_STATS_EN
            grants0_q  <= '0;
            grants1_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
`ifdef BINMUX_ARB_STATS_EN
            grants0_q  <= grants0_d;
            grants1_q  <= grants1_d;
`endif
        end
    end

    always_comb begin
        state_d    = (xfer || (state_q == ARB_FULL && !out_ready)) ? ARB_FULL : ARB_EMPTY;
        last_gnt_d = xfer ? sel : last_gnt_q;
        out_data_d = xfer ? mux_data : out_data_q;
        out_src_d  = xfer ? sel : out_src_q;
`ifdef BINMUX_ARB_STATS_EN
        grants0_d  = (xfer && !sel && grants0_q != 8'hFF) ? grants0_q + 8'd1 : grants0_q;
        grants1_d  = (xfer &&  sel && grants1_q != 8'hFF) ? grants1_q + 8'd1 : grants1_q;
`endif
    end

    always_comb begin
        out_valid  = (state_q == ARB_FULL);
        out_data   = out_data_q;
        out_src    = out_src_q;
        in0_ready  = take && !sel;
        in1_ready  = take && sel;
`ifdef BINMUX_ARB_STATS_EN
        in0_grants = grants0_q;
        in1_grants = grants1_q;
`endif
    end
endmodule

// File: tb/tb_binmux_arb.sv
// tb_binmux_arb: directed self-checking bench for binmux_arb.
// Grant counter checks are built only when BINMUX_ARB_STATS_EN is defined.
module tb_binmux_arb;
    logic       clk, rst_n;
    logic       in0_valid, in1_valid, in0_ready, in1_ready;
    logic [7:0] in0_data, in1_data, out_data;
    logic       out_valid, out_ready, out_src;
`ifdef BINMUX_ARB_STATS_EN
    logic [7:0] in0_grants, in1_grants;
`endif
    int checks = 0;
    int errors = 0;

    binmux_arb #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef BINMUX_ARB_STATS_EN
        .in0_grants(in0_grants),
        .in1_grants(in1_grants),
`endif
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
        rst_n = 0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h src=%b, want 0 00 0", out_valid, out_data, out_src);
        end
        rst_n = 1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got r0=%b r1=%b, want 1 0", in0_ready, in1_ready);
        end
    endtask

    task automatic test_single();
        in0_valid = 1; in0_data = 8'hA5; out_ready = 1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got r0=%b r1=%b, want 1 0", in0_ready, in1_ready);
        end
        step();
        in0_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h src=%b, want 1 a5 0", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_drain();
        out_ready = 1; in0_valid = 0; in1_valid = 0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL drain: got valid=%b data=%h, want 0 a5", out_valid, out_data);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        in0_valid = 1; in0_data = 8'h11; in1_valid = 1; in1_data = 8'h22; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in0_ready !== !exp_s[i] || in1_ready !== exp_s[i]) begin
                errors++;
                $display("FAIL contend_ready[%0d]: got r0=%b r1=%b, want %b %b", i, in0_ready, in1_ready, !exp_s[i], exp_s[i]);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== exp_s[i]) begin
                errors++;
                $display("FAIL contend_out[%0d]: got valid=%b data=%h src=%b, want 1 %h %b", i, out_valid, out_data, out_src, exp_d[i], exp_s[i]);
            end
        end
        in0_valid = 0; in1_valid = 0;
    endtask

    task automatic test_stall();
        in0_valid = 1; in0_data = 8'h33; in1_valid = 0; out_ready = 1;
        step();
        in0_valid = 0; in1_valid = 1; in1_data = 8'h44; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got r0=%b r1=%b, want 0 0", i, in0_ready, in1_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_src !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h src=%b, want 1 33 0", i, out_valid, out_data, out_src);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_ready: got r0=%b r1=%b, want 0 1", in0_ready, in1_ready);
        end
        step();
        in1_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h44 || out_src !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_out: got valid=%b data=%h src=%b, want 1 44 1", out_valid, out_data, out_src);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h44 || out_src !== 1'b1) begin
            errors++;
            $display("FAIL stall_drain: got valid=%b data=%h src=%b, want 0 44 1", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h03};
        out_ready = 1; in0_valid = 0; in1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in1_data = vals[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || out_src !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got valid=%b data=%h src=%b, want 1 %h 1", i, out_valid, out_data, out_src, vals[i]);
            end
        end
        in1_valid = 0;
        step();
    endtask

    task automatic test_async_reset();
        in0_valid = 1; in0_data = 8'h5A; out_ready = 1;
        step();
        in0_valid = 0; out_ready = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h src=%b, want 0 00 0", out_valid, out_data, out_src);
        end
        rst_n = 1;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_release_ready: got r0=%b r1=%b, want 1 0", in0_ready, in1_ready);
        end
        step();
    endtask

`ifdef BINMUX_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        in0_valid = 1; in0_data = 8'h77; out_ready = 1;
        for (int i = 0; i < 300; i++) step();
        in0_valid = 0;
        checks++;
        if (in0_grants !== 8'd255 || in1_grants !== 8'd0) begin
            errors++;
            $display("FAIL stats_sat: got g0=%0d g1=%0d, want 255 0", in0_grants, in1_grants);
        end
        in1_valid = 1; in1_data = 8'h78;
        step();
        in1_valid = 0;
        checks++;
        if (in0_grants !== 8'd255 || in1_grants !== 8'd1) begin
            errors++;
            $display("FAIL stats_in1: got g0=%0d g1=%0d, want 255 1", in0_grants, in1_grants);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_drain();
        test_contention();
        test_stall();
        test_back_to_back();
        test_async_reset();
`ifdef BINMUX_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
